// File: rtl/sram_pkg.sv
// sram_pkg: shared slot-phase constants, grant encoding and grant-selection helper for the SRAM arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sram_pkg;

  localparam int AW_DEF = 21;

  // Fixed four-clock frame: two video clocks, then one aux setup clock and one aux access clock.
  localparam logic [1:0] PH_VADDR     = 2'd0;
  localparam logic [1:0] PH_VHOLD     = 2'd1;
  localparam logic [1:0] PH_AUX_SETUP = 2'd2;
  localparam logic [1:0] PH_AUX_ACC   = 2'd3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

  // Aux-slot winner. With ld_prio the loader always wins. Without it, a tie goes to
  // whichever requester did not win the previous aux grant.
  function automatic gnt_e pick_grant(input logic ld_pend, input logic cpu_pend,
                                      input logic ld_prio, input logic last_ld);
    gnt_e g;
    g = GNT_NONE;
    if (ld_pend && cpu_pend) begin
      if (ld_prio) g = GNT_LD;
      else         g = last_ld ? GNT_CPU : GNT_LD;
    end else if (ld_pend) begin
      g = GNT_LD;
    end else if (cpu_pend) begin
      g = GNT_CPU;
    end
    return g;
  endfunction

endpackage

// File: rtl/sram_wfifo.sv
// sram_wfifo: synchronous FIFO that buffers loader writes ({address, data}) until an aux slot takes them.
// Latency: a pushed entry is visible at pop_dat the clock after the push; full, empty and count are registered.
// Backpressure: a push while full is ignored and a pop while empty is ignored; the caller watches full.
// Ports: clock, reset_n; push/push_dat write side; pop/pop_dat read side (pop_dat shows the head entry);
//        full, empty, count status.
module sram_wfifo #(
  parameter int W     = 29,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [W-1:0]              push_dat,
  input  logic                      pop,
  output logic [W-1:0]              pop_dat,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  // Push and pop are qualified against the pre-edge flags, so a push into a full FIFO
  // is dropped even when a pop frees a slot in the same clock.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/sram_slot_arbiter.sv
// sram_slot_arbiter: time-slotted sharing of one async 8-bit SRAM between video fetch, loader writes and a CPU port.
// Latency: fixed 4-clock frame; video data 2 clocks after its address edge; CPU ack in the phase 0 after its aux slot.
// Backpressure: loader stalls on ld_busy (FIFO full); CPU holds its request until cpu_ack; video never stalls.
// Ports: clock, reset_n; phase (current slot); vid_a/vid_q/vid_valid (video read slot);
//        ld_wr/ld_a/ld_d/ld_busy/ld_overflow (loader); cpu_req/we/a/d/q/ack (CPU);
//        sram_a/we_n/dq_o/dq_oe/dq_i (SRAM pins; the top level owns the DQ tri-state).
module sram_slot_arbiter
  import sram_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int LD_PRIO    = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [1:0]    phase,
  input  logic [AW-1:0] vid_a,
  output logic [7:0]    vid_q,
  output logic          vid_valid,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_a,
  input  logic [7:0]    ld_d,
  output logic          ld_busy,
  output logic          ld_overflow,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_q,
  output logic          cpu_ack,
  output logic [AW-1:0] sram_a,
  output logic          sram_we_n,
  output logic [7:0]    sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [7:0]    sram_dq_i
);

  localparam int FW = AW + 8;

  logic [FW-1:0]                 fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_pop;
  gnt_e                          gnt;
  gnt_e                          gnt_nxt;
  logic                          last_ld;

  // The loader entry stays at the FIFO head for the whole aux slot and is
  // popped on the edge that closes it (into phase 0).
  assign fifo_pop = (phase == PH_AUX_ACC) && (gnt == GNT_LD) && (fifo_count != '0);

  sram_wfifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (ld_wr),
    .push_dat ({ld_a, ld_d}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ld_busy is the FIFO's registered full flag, so it rises the clock after the filling push.
  assign ld_busy = fifo_full;

  assign gnt_nxt = pick_grant(!fifo_empty, cpu_req, (LD_PRIO != 0), last_ld);

  // Each case arm computes the bus state for the phase being entered:
  // the arm for phase N drives what the pins show during phase N+1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase       <= PH_VADDR;
      sram_a      <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_o   <= '0;
      sram_dq_oe  <= 1'b0;
      vid_q       <= '0;
      vid_valid   <= 1'b0;
      cpu_q       <= '0;
      cpu_ack     <= 1'b0;
      ld_overflow <= 1'b0;
      gnt         <= GNT_NONE;
      last_ld     <= 1'b0;
    end else begin
      phase     <= phase + 2'd1;
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      if (ld_wr && fifo_full) ld_overflow <= 1'b1;

      case (phase)
        PH_AUX_ACC: begin
          // Into phase 0: end any write (zero SRAM hold time) and present the video address.
          sram_a     <= vid_a;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          if (gnt == GNT_CPU) begin
            cpu_ack <= 1'b1;
            // dq_oe still low here means the CPU access was a read.
            if (!sram_dq_oe) cpu_q <= sram_dq_i;
          end
          gnt <= GNT_NONE;
        end
        PH_VADDR: begin
          // Into phase 1: the video address is simply held.
        end
        PH_VHOLD: begin
          // Into phase 2: capture video data, then set up the aux access.
          vid_q     <= sram_dq_i;
          vid_valid <= 1'b1;
          gnt       <= gnt_nxt;
          if (gnt_nxt != GNT_NONE) last_ld <= (gnt_nxt == GNT_LD);
          case (gnt_nxt)
            GNT_LD: begin
              sram_a     <= fifo_head[FW-1:8];
              sram_dq_o  <= fifo_head[7:0];
              sram_dq_oe <= 1'b1;
            end
            GNT_CPU: begin
              sram_a     <= cpu_a;
              sram_dq_o  <= cpu_d;
              sram_dq_oe <= cpu_we;
            end
            default: begin
              // Idle aux slot: bus stays in read mode on the video address.
            end
          endcase
        end
        PH_AUX_SETUP: begin
          // Into phase 3: strobe write enable only after a full setup clock.
          if (sram_dq_oe) sram_we_n <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
module tb_sram_slot_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [20:0] vid_a = 21'h00100;
  logic        ld_wr = 1'b0;
  logic [20:0] ld_a = '0;
  logic [7:0]  ld_d = '0;
  logic        cpu_req_a = 1'b0;
  logic        cpu_req_b = 1'b0;
  logic        cpu_we = 1'b0;
  logic [20:0] cpu_a = '0;
  logic [7:0]  cpu_d = '0;

  // Instance A: LD_PRIO = 1, instance B: LD_PRIO = 0.
  logic [1:0]  phase_a, phase_b;
  logic [7:0]  vid_q_a, vid_q_b, cpu_q_a, cpu_q_b;
  logic        vid_valid_a, vid_valid_b, ld_busy_a, ld_busy_b, ld_ovf_a, ld_ovf_b;
  logic        cpu_ack_a, cpu_ack_b;
  logic [20:0] sram_a_a, sram_a_b;
  logic        we_n_a, we_n_b, oe_a, oe_b;
  logic [7:0]  dq_o_a, dq_o_b, dq_i_a, dq_i_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sram_slot_arbiter #(.AW(21), .FIFO_DEPTH(4), .LD_PRIO(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .phase(phase_a),
    .vid_a(vid_a), .vid_q(vid_q_a), .vid_valid(vid_valid_a),
    .ld_wr(ld_wr), .ld_a(ld_a), .ld_d(ld_d), .ld_busy(ld_busy_a), .ld_overflow(ld_ovf_a),
    .cpu_req(cpu_req_a), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q_a), .cpu_ack(cpu_ack_a),
    .sram_a(sram_a_a), .sram_we_n(we_n_a), .sram_dq_o(dq_o_a), .sram_dq_oe(oe_a), .sram_dq_i(dq_i_a)
  );

  sram_slot_arbiter #(.AW(21), .FIFO_DEPTH(4), .LD_PRIO(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .phase(phase_b),
    .vid_a(vid_a), .vid_q(vid_q_b), .vid_valid(vid_valid_b),
    .ld_wr(ld_wr), .ld_a(ld_a), .ld_d(ld_d), .ld_busy(ld_busy_b), .ld_overflow(ld_ovf_b),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q_b), .cpu_ack(cpu_ack_b),
    .sram_a(sram_a_b), .sram_we_n(we_n_b), .sram_dq_o(dq_o_b), .sram_dq_oe(oe_b), .sram_dq_i(dq_i_b)
  );

  // SRAM models: 1K window on address bits [9:0]; unwritten locations return preset contents.
  bit [7:0]    mem_a [0:1023];
  bit [7:0]    mem_b [0:1023];
  bit          wv_a  [0:1023];
  bit          wv_b  [0:1023];
  int          wr_cnt_a = 0, wr_cnt_b = 0, viol_a = 0, viol_b = 0;
  logic [20:0] wlog_a [$];
  logic [20:0] wlog_b [$];

  function automatic logic [7:0] preload(input logic [9:0] idx);
    if (idx == 10'h100) return 8'hA5;
    if (idx == 10'h3FF) return 8'h3C;
    return 8'h00;
  endfunction

  assign dq_i_a = wv_a[sram_a_a[9:0]] ? mem_a[sram_a_a[9:0]] : preload(sram_a_a[9:0]);
  assign dq_i_b = wv_b[sram_a_b[9:0]] ? mem_b[sram_a_b[9:0]] : preload(sram_a_b[9:0]);

  always @(posedge clock) begin
    if (we_n_a === 1'b0) begin
      mem_a[sram_a_a[9:0]] <= dq_o_a;
      wv_a[sram_a_a[9:0]]  <= 1'b1;
      wr_cnt_a <= wr_cnt_a + 1;
      wlog_a.push_back(sram_a_a);
    end
    if (we_n_b === 1'b0) begin
      mem_b[sram_a_b[9:0]] <= dq_o_b;
      wv_b[sram_a_b[9:0]]  <= 1'b1;
      wr_cnt_b <= wr_cnt_b + 1;
      wlog_b.push_back(sram_a_b);
    end
  end

  // A write strobe is legal only in phase 3 with the data drivers on.
  always @(negedge clock) begin
    if (we_n_a === 1'b0 && (phase_a !== 2'd3 || oe_a !== 1'b1)) viol_a <= viol_a + 1;
    if (we_n_b === 1'b0 && (phase_b !== 2'd3 || oe_b !== 1'b1)) viol_b <= viol_b + 1;
  end

  task automatic sync_phase(input logic [1:0] p);
    int n;
    n = 0;
    @(negedge clock);
    while (phase_a !== p && n < 8) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (phase_a !== p) begin
      errors++;
      $display("FAIL sync_phase: phase=%0d required %0d", phase_a, p);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks += 6;
    if (phase_a !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d required 0", phase_a); end
    if ({sram_a_a, we_n_a, oe_a, dq_o_a} !== {21'h0, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_bus: a=%h we_n=%b oe=%b dq_o=%h required 0/1/0/0", sram_a_a, we_n_a, oe_a, dq_o_a);
    end
    if ({vid_q_a, vid_valid_a} !== 9'h0) begin errors++; $display("FAIL reset_vid: q=%h valid=%b required 0/0", vid_q_a, vid_valid_a); end
    if ({cpu_q_a, cpu_ack_a} !== 9'h0) begin errors++; $display("FAIL reset_cpu: q=%h ack=%b required 0/0", cpu_q_a, cpu_ack_a); end
    if ({ld_busy_a, ld_ovf_a} !== 2'b00) begin errors++; $display("FAIL reset_ld: busy=%b ovf=%b required 0/0", ld_busy_a, ld_ovf_a); end
    if ({phase_b, we_n_b, oe_b} !== {2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL reset_b: phase=%0d we_n=%b oe=%b", phase_b, we_n_b, oe_b); end
    reset_n = 1'b1;
  endtask

  task automatic test_video;
    logic [1:0] exp_ph;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      exp_ph = 2'(i % 4);
      checks += 3;
      if (phase_a !== exp_ph) begin errors++; $display("FAIL vid_phase: cycle %0d got %0d required %0d", i, phase_a, exp_ph); end
      if (vid_valid_a !== (exp_ph == 2'd2)) begin errors++; $display("FAIL vid_valid: cycle %0d got %b", i, vid_valid_a); end
      if (we_n_a !== 1'b1 || oe_a !== 1'b0) begin errors++; $display("FAIL vid_bus_idle: cycle %0d we_n=%b oe=%b", i, we_n_a, oe_a); end
      // The first frame after reset fetched from address 0, later frames from vid_a.
      if (exp_ph == 2'd2 && i > 2) begin
        checks++;
        if (vid_q_a !== 8'hA5) begin errors++; $display("FAIL vid_q: cycle %0d got %h required a5", i, vid_q_a); end
      end
    end
  endtask

  task automatic test_loader_fill;
    int wa0, wb0;
    logic exp_busy, exp_ovf;
    wa0 = wr_cnt_a;
    wb0 = wr_cnt_b;
    sync_phase(2'd2);
    for (int k = 0; k < 5; k++) begin
      ld_wr = 1'b1;
      ld_a  = 21'(k);
      ld_d  = 8'(8'h10 + k);
      @(negedge clock);
      exp_busy = (k >= 3);
      exp_ovf  = (k == 4);
      checks += 2;
      if (ld_busy_a !== exp_busy) begin errors++; $display("FAIL ld_busy: strobe %0d got %b required %b", k, ld_busy_a, exp_busy); end
      if (ld_ovf_a !== exp_ovf) begin errors++; $display("FAIL ld_overflow: strobe %0d got %b required %b", k, ld_ovf_a, exp_ovf); end
    end
    ld_wr = 1'b0;
    @(negedge clock);
    checks++;
    if (ld_busy_a !== 1'b0) begin errors++; $display("FAIL ld_busy_after_pop: got %b required 0", ld_busy_a); end
    repeat (20) @(negedge clock);
    checks += 5;
    if (wr_cnt_a - wa0 !== 4) begin errors++; $display("FAIL ld_write_count_a: got %0d required 4", wr_cnt_a - wa0); end
    if (wr_cnt_b - wb0 !== 4) begin errors++; $display("FAIL ld_write_count_b: got %0d required 4", wr_cnt_b - wb0); end
    if (viol_a !== 0 || viol_b !== 0) begin errors++; $display("FAIL we_n_outside_phase3: a=%0d b=%0d required 0", viol_a, viol_b); end
    if ({mem_a[0], mem_a[1], mem_a[2], mem_a[3]} !== 32'h10111213) begin
      errors++; $display("FAIL ld_mem: got %h %h %h %h required 10 11 12 13", mem_a[0], mem_a[1], mem_a[2], mem_a[3]);
    end
    if (wv_a[4] !== 1'b0 || ld_ovf_a !== 1'b1) begin errors++; $display("FAIL ld_drop: addr4 written=%b ovf=%b required 0/1", wv_a[4], ld_ovf_a); end
  endtask

  task automatic test_cpu_read;
    int acks;
    sync_phase(2'd1);
    cpu_we = 1'b0; cpu_a = 21'h1FFFF; cpu_d = 8'h00;
    cpu_req_a = 1'b1; cpu_req_b = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      checks++;
      if (cpu_ack_a !== (i == 3)) begin errors++; $display("FAIL cpu_ack_timing: cycle %0d got %b", i, cpu_ack_a); end
      if (i == 1) begin
        checks++;
        if (vid_valid_a !== 1'b1 || vid_q_a !== 8'hA5) begin
          errors++; $display("FAIL cpu_vid_slot: valid=%b q=%h required 1/a5", vid_valid_a, vid_q_a);
        end
      end
    end
    checks += 2;
    if (cpu_q_a !== 8'h3C || cpu_q_b !== 8'h3C) begin errors++; $display("FAIL cpu_q: a=%h b=%h required 3c", cpu_q_a, cpu_q_b); end
    if (cpu_ack_b !== 1'b1) begin errors++; $display("FAIL cpu_ack_b: got %b required 1", cpu_ack_b); end
    cpu_req_a = 1'b0; cpu_req_b = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clock);
      if (cpu_ack_a === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL cpu_extra_ack: got %0d required 0", acks); end
  endtask

  task automatic test_arbitration;
    int slot, ack_slot_a, ack_slot_b, na, nb;
    logic [20:0] exp_a [4];
    logic [20:0] exp_b [4];
    exp_a[0] = 21'h10; exp_a[1] = 21'h11; exp_a[2] = 21'h12; exp_a[3] = 21'h200;
    exp_b[0] = 21'h10; exp_b[1] = 21'h200; exp_b[2] = 21'h11; exp_b[3] = 21'h12;
    na = wlog_a.size();
    nb = wlog_b.size();
    slot = -1; ack_slot_a = -1; ack_slot_b = -1;
    sync_phase(2'd3);
    cpu_we = 1'b1; cpu_a = 21'h00200; cpu_d = 8'h77;
    cpu_req_a = 1'b1; cpu_req_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ld_wr = (i < 3);
      ld_a  = 21'(8'h10 + i);
      ld_d  = 8'(8'hA0 + i);
      @(negedge clock);
      if (phase_a == 2'd0) slot++;
      if (cpu_ack_a === 1'b1) begin ack_slot_a = slot; cpu_req_a = 1'b0; end
      if (cpu_ack_b === 1'b1) begin ack_slot_b = slot; cpu_req_b = 1'b0; end
    end
    ld_wr = 1'b0;
    checks += 4;
    if (ack_slot_a !== 4) begin errors++; $display("FAIL prio1_ack_slot: got %0d required 4", ack_slot_a); end
    if (ack_slot_b !== 2) begin errors++; $display("FAIL rr_ack_slot: got %0d required 2", ack_slot_b); end
    if (wlog_a.size() !== na + 4 || wlog_b.size() !== nb + 4) begin
      errors++; $display("FAIL arb_write_count: a=%0d b=%0d required 4", wlog_a.size() - na, wlog_b.size() - nb);
    end
    if (mem_a[10'h200] !== 8'h77 || mem_b[10'h200] !== 8'h77) begin
      errors++; $display("FAIL cpu_write_data: a=%h b=%h required 77", mem_a[10'h200], mem_b[10'h200]);
    end
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (wlog_a.size() > na + k && wlog_a[na + k] !== exp_a[k]) begin
        errors++; $display("FAIL prio1_order: slot %0d got %h required %h", k + 1, wlog_a[na + k], exp_a[k]);
      end
      if (wlog_b.size() > nb + k && wlog_b[nb + k] !== exp_b[k]) begin
        errors++; $display("FAIL rr_order: slot %0d got %h required %h", k + 1, wlog_b[nb + k], exp_b[k]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int wa0;
    sync_phase(2'd0);
    ld_wr = 1'b1; ld_a = 21'h20; ld_d = 8'hB0;
    @(negedge clock);
    ld_a = 21'h21; ld_d = 8'hB1;
    @(negedge clock);
    ld_wr = 1'b0;
    @(negedge clock);
    checks++;
    if (phase_a !== 2'd3 || we_n_a !== 1'b0 || sram_a_a !== 21'h20) begin
      errors++; $display("FAIL abort_setup: phase=%0d we_n=%b a=%h required 3/0/20", phase_a, we_n_a, sram_a_a);
    end
    wa0 = wr_cnt_a;
    reset_n = 1'b0;
    #1;
    checks += 2;
    if (we_n_a !== 1'b1 || oe_a !== 1'b0) begin errors++; $display("FAIL abort_async: we_n=%b oe=%b required 1/0", we_n_a, oe_a); end
    if (phase_a !== 2'd0) begin errors++; $display("FAIL abort_phase: got %0d required 0", phase_a); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks += 2;
    if (phase_a !== 2'd0) begin errors++; $display("FAIL release_phase: got %0d required 0", phase_a); end
    if (ld_busy_a !== 1'b0 || ld_ovf_a !== 1'b0) begin errors++; $display("FAIL release_ld: busy=%b ovf=%b required 0/0", ld_busy_a, ld_ovf_a); end
    repeat (16) @(negedge clock);
    checks += 2;
    if (wr_cnt_a !== wa0) begin errors++; $display("FAIL fifo_flushed: %0d writes after reset required 0", wr_cnt_a - wa0); end
    if (wv_a[10'h20] !== 1'b0 || wv_a[10'h21] !== 1'b0) begin errors++; $display("FAIL abort_mem: 20 written=%b 21 written=%b", wv_a[10'h20], wv_a[10'h21]); end
  endtask

  initial begin
    test_reset();
    test_video();
    test_loader_fill();
    test_cpu_read();
    test_arbitration();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
